// File: rtl/tap_buffer_sequencer.sv
// ============================================================================
// tap_buffer_sequencer
//
// Purpose:
//   Keeps a circular history of ADC samples in an external single-port block
//   RAM. It also replays the most recent N_TAPS samples as a tap stream for a
//   downstream FIR-style consumer. Each accepted sample is written once. The
//   buffer is then read newest-first (k = 0 .. N_TAPS-1), and each RAM word is
//   forwarded one cycle later, which matches the RAM read latency.
//
// Ports:
//   clk_100M      in   system clock, all logic on its rising edge
//   rst_n         in   synchronous active-low reset
//   sample_valid  in   one-cycle pulse, new sample on sample_in
//   sample_in     in   [DATA_W] sample, captured only while idle
//   ram_addr      out  [ADDR_W] block RAM address
//   ram_we        out  block RAM write enable
//   ram_din       out  [DATA_W] block RAM write data (holds between writes)
//   ram_dout      in   [DATA_W] block RAM read data, one cycle after ram_addr
//   tap_valid     out  tap_data / tap_index valid this cycle
//   tap_data      out  [DATA_W] delayed sample x[n-k]
//   tap_index     out  [ADDR_W] k, 0 = newest
//   tap_last      out  marks k = N_TAPS-1
//   busy          out  a write/read sequence is running
//   overrun       out  sticky, a sample arrived while busy and was dropped
// ============================================================================
module tap_buffer_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int N_TAPS = 16
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              tap_valid,
    output logic [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0] tap_index,
    output logic              tap_last,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(N_TAPS);
    localparam logic [ADDR_W:0]   ONE_F    = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    // One bit wider than the address so it can hold N_TAPS = 2^ADDR_W.
    logic [ADDR_W:0]     fill_q, fill_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                overrun_q, overrun_d;
    logic                tap_valid_q, tap_valid_d;
    logic                tap_last_q, tap_last_d;
    logic [ADDR_W-1:0]   tap_index_q, tap_index_d;

    // State register. Reset wins over everything, so an in-flight write is
    // abandoned and the fill increment on WRITE exit never happens.
    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            fill_q      <= '0;
            sample_q    <= '0;
            overrun_q   <= 1'b0;
            tap_valid_q <= 1'b0;
            tap_last_q  <= 1'b0;
            tap_index_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            fill_q      <= fill_d;
            sample_q    <= sample_d;
            overrun_q   <= overrun_d;
            tap_valid_q <= tap_valid_d;
            tap_last_q  <= tap_last_d;
            tap_index_q <= tap_index_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        k_d       = k_q;
        fill_d    = fill_q;
        sample_d  = sample_q;
        overrun_d = overrun_q;

        // The tap qualifiers lag the read address by one cycle so that they
        // line up with ram_dout.
        tap_valid_d = (state_q == READ);
        tap_last_d  = (state_q == READ) && (k_q == LAST_K);
        tap_index_d = (state_q == READ) ? k_q : '0;

        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    sample_d = sample_in;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                state_d = READ;
                k_d     = '0;
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + ONE_F;
                end
            end
            READ: begin
                if (k_q == LAST_K) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + ONE_A;
                end
            end
            DRAIN: begin
                // The pointer moves only once the whole read pass is done,
                // so every read is taken relative to the slot just written.
                state_d  = IDLE;
                wr_ptr_d = wr_ptr_q + ONE_A;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A sample arriving in any non-idle state, including the last DRAIN
        // cycle, is dropped and flagged.
        if (sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        busy      = (state_q != IDLE);
        ram_we    = (state_q == WRITE);
        ram_din   = sample_q;
        overrun   = overrun_q;
        tap_valid = tap_valid_q;
        tap_last  = tap_last_q;
        tap_index = tap_index_q;

        unique case (state_q)
            WRITE:   ram_addr = wr_ptr_q;
            // Unsigned subtraction wraps modulo the buffer depth.
            READ:    ram_addr = wr_ptr_q - k_q;
            default: ram_addr = '0;
        endcase

        // Slots that have not been written since reset read back as zero.
        if (tap_valid_q && ({1'b0, tap_index_q} < fill_q)) begin
            tap_data = ram_dout;
        end else begin
            tap_data = '0;
        end
    end

endmodule
